sram_access_arbiter: RTL and testbench

//  Shares the single async 8-bit SRAM between the capture writer (RPi pixel stream) and the VGA

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/sram_wr_fifo.sv | 53 +++++
 rtl/sram_access_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter: FSM encoding,
// default geometry and the active-low strobe levels.
package sram_arb_pkg;

    localparam int DEF_ADDR_W      = 18;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_WBUF_DEPTH  = 4;
    localparam int DEF_FRAME_WORDS = 262144;
    localparam int DEF_MAX_RD_WIN  = 8;

    // SRAM control pins are active low.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ADDR  = 3'd1,
        ST_RD_CAP   = 3'd2,
        ST_WR_ADDR  = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } arb_state_t;

endpackage

// File: rtl/sram_wr_fifo.sv
// Small synchronous FIFO holding pending {addr,data} SRAM writes.
// The head entry is visible combinationally so the arbiter can latch it at grant.
module sram_wr_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only pointers and count are reset,
    // and an entry is never read before it has been written.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one async SRAM between the capture writer and the display reader,
// sequencing every SRAM cycle; reads have priority with a write anti-starvation guard.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WBUF_DEPTH  = DEF_WBUF_DEPTH,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int MAX_RD_WIN  = DEF_MAX_RD_WIN
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              en,
    input  logic              wr_valid,
    input  logic              wr_sof,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_overflow,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_cs_n,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(WBUF_DEPTH) + 1;
    localparam int WIN_W   = $clog2(MAX_RD_WIN + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(WBUF_DEPTH);
    localparam logic [WIN_W-1:0]  WIN_LIMIT = WIN_W'(MAX_RD_WIN);

    arb_state_t        state;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] push_addr;
    logic              push;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              wbuf_full;
    logic              wbuf_empty;
    logic [CNT_W-1:0]  wbuf_count;
    logic [WIN_W-1:0]  rd_win;
    logic              guard_hit;
    logic              grant_rd;
    logic              grant_wr;

    assign wr_ready  = (wbuf_count != FULL_CNT);
    assign push      = wr_valid && wr_ready;
    assign push_addr = wr_sof ? '0 : next_addr;
    assign head_addr = head[ENTRY_W-1:DATA_W];
    assign head_data = head[DATA_W-1:0];
    assign guard_hit = wbuf_full && (rd_win >= WIN_LIMIT);

    sram_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wr_fifo (
        .clk_in    (clk_in),
        .reset     (reset),
        .push      (push),
        .push_data ({push_addr, wr_data}),
        .pop       (grant_wr),
        .head      (head),
        .full      (wbuf_full),
        .empty     (wbuf_empty),
        .count     (wbuf_count)
    );

    always_comb begin
        // NOTE: both grants get a default before any branch so no path infers a latch.
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == ST_IDLE && en) begin
            if (guard_hit)        grant_wr = 1'b1;
            else if (rd_req)      grant_rd = 1'b1;
            else if (!wbuf_empty) grant_wr = 1'b1;
        end
    end

    // Capture address generator and sticky drop flag.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            next_addr   <= '0;
            wr_overflow <= 1'b0;
        end else if (push) begin
            next_addr <= (push_addr == LAST_ADDR) ? '0 : push_addr + 1'b1;
            if (wr_sof) wr_overflow <= 1'b0;
        end else if (wr_valid) begin
            wr_overflow <= 1'b1;
        end
    end

    // Counts reads that jumped ahead of a full write buffer.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rd_win <= '0;
        end else if (grant_wr) begin
            rd_win <= '0;
        end else if (grant_rd && wbuf_full && rd_win != WIN_LIMIT) begin
            rd_win <= rd_win + 1'b1;
        end
    end

    // NOTE: every register here uses <= so all of them update from pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= ST_IDLE;
            rd_ack      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_cs_n   <= STROBE_OFF;
            sram_we_n   <= STROBE_OFF;
            sram_oe_n   <= STROBE_OFF;
        end else begin
            rd_ack   <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_wr) begin
                        state       <= ST_WR_ADDR;
                        sram_addr   <= head_addr;
                        sram_dq_out <= head_data;
                        sram_dq_oe  <= 1'b1;
                        sram_cs_n   <= STROBE_ON;
                    end else if (grant_rd) begin
                        state     <= ST_RD_ADDR;
                        sram_addr <= rd_addr;
                        sram_oe_n <= STROBE_ON;
                        sram_cs_n <= STROBE_ON;
                        rd_ack    <= 1'b1;
                    end
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    state     <= ST_IDLE;
                    rd_data   <= sram_dq_in;
                    rd_valid  <= 1'b1;
                    sram_oe_n <= STROBE_OFF;
                    sram_cs_n <= STROBE_OFF;
                end
                ST_WR_ADDR: begin
                    state     <= ST_WR_PULSE;
                    sram_we_n <= STROBE_ON;
                end
                ST_WR_PULSE: begin
                    state     <= ST_WR_HOLD;
                    sram_we_n <= STROBE_OFF;
                end
                ST_WR_HOLD: begin
                    state      <= ST_IDLE;
                    sram_dq_oe <= 1'b0;
                    sram_cs_n  <= STROBE_OFF;
                end
                default: begin
                    state      <= ST_IDLE;
                    sram_dq_oe <= 1'b0;
                    sram_cs_n  <= STROBE_OFF;
                    sram_we_n  <= STROBE_OFF;
                    sram_oe_n  <= STROBE_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter with a behavioural async SRAM.
module tb_sram_access_arbiter;

    localparam int ADDR_W      = 18;
    localparam int DATA_W      = 8;
    localparam int WBUF_DEPTH  = 4;
    localparam int FRAME_WORDS = 16;
    localparam int MAX_RD_WIN  = 8;

    logic              clk_in = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_sof = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              wr_overflow;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;
    logic              sram_cs_n;
    logic              sram_we_n;
    logic              sram_oe_n;

    always #5 clk_in = ~clk_in;

    sram_access_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WBUF_DEPTH  (WBUF_DEPTH),
        .FRAME_WORDS (FRAME_WORDS),
        .MAX_RD_WIN  (MAX_RD_WIN)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .en          (en),
        .wr_valid    (wr_valid),
        .wr_sof      (wr_sof),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_overflow (wr_overflow),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_cs_n   (sram_cs_n),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Unwritten locations return a fixed pattern; 0x10 holds 0x3C.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] lo;
        lo = a[DATA_W-1:0];
        return (a == 18'h10) ? 8'h3C : (lo ^ 8'h5A);
    endfunction

    logic [DATA_W-1:0] sram_mem [1024];
    bit                written  [1024];

    always @(posedge clk_in) begin
        if (!sram_cs_n && !sram_we_n) begin
            sram_mem[sram_addr[9:0]] <= sram_dq_out;
            written[sram_addr[9:0]]  <= 1'b1;
        end
    end

    assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ?
                        (written[sram_addr[9:0]] ? sram_mem[sram_addr[9:0]] : pat(sram_addr)) : '0;

    logic [ADDR_W+DATA_W-1:0] wr_q [$];
    logic [DATA_W-1:0]        rd_q [$];
    logic [ADDR_W-1:0]        wr_log [$];
    logic [ADDR_W-1:0]        m_next = '0;
    bit                       we_low_prev = 1'b0;

    // Write monitor: each WE pulse must match the next pushed pixel.
    always @(negedge clk_in) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (!reset && !sram_we_n) begin
            check("we_single_cycle", 32'(we_low_prev), 0);
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 32'(sram_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                check("wr_data", 32'(sram_dq_out), 32'(e[DATA_W-1:0]));
                check("wr_oe_n", 32'(sram_oe_n), 1);
                check("wr_dq_oe", 32'(sram_dq_oe), 1);
                check("wr_cs_n", 32'(sram_cs_n), 0);
            end
            wr_log.push_back(sram_addr);
        end
        we_low_prev = !reset && !sram_we_n;
    end

    // Read monitor: accepted requests queue their expected data.
    always @(negedge clk_in) begin
        if (!reset) begin
            if (rd_ack) rd_q.push_back(pat(rd_addr));
            if (rd_valid) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else                  check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
        end
    end

    task automatic drive_px(input logic [DATA_W-1:0] d, input logic sof);
        logic [ADDR_W-1:0] a;
        wr_valid = 1'b1;
        wr_sof   = sof;
        wr_data  = d;
        if (wr_ready) begin
            a = sof ? '0 : m_next;
            wr_q.push_back({a, d});
            m_next = (a == ADDR_W'(FRAME_WORDS - 1)) ? '0 : a + 1'b1;
        end
    endtask

    task automatic push_px(input logic [DATA_W-1:0] d, input logic sof, input bit wait_rdy);
        int n;
        n = 0;
        @(negedge clk_in);
        while (wait_rdy && !wr_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (wait_rdy && !wr_ready) check("push_wait_timeout", 1, 0);
        drive_px(d, sof);
        @(negedge clk_in);
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset    = 1'b1;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        rd_req   = 1'b0;
        wr_q.delete();
        rd_q.delete();
        wr_log.delete();
        m_next = '0;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output int ack_lat, output int val_lat);
        @(negedge clk_in);
        rd_req  = 1'b1;
        rd_addr = a;
        ack_lat = -1;
        val_lat = -1;
        for (int i = 1; i <= 40 && val_lat < 0; i++) begin
            @(negedge clk_in);
            if (rd_ack && ack_lat < 0) begin
                ack_lat = i;
                rd_req  = 1'b0;
            end
            if (rd_valid && ack_lat >= 0) val_lat = i;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_lat, val_lat, acks, seen, n, cs_seen;
        int runs [2];

        // Reset values and a single sof write.
        do_reset();
        check("rst_rd_ack", 32'(rd_ack), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_sram_addr", 32'(sram_addr), 0);
        check("rst_dq_out", 32'(sram_dq_out), 0);
        check("rst_dq_oe", 32'(sram_dq_oe), 0);
        check("rst_strobes", 32'({sram_cs_n, sram_we_n, sram_oe_n}), 3'b111);
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_overflow", 32'(wr_overflow), 0);
        en = 1'b1;
        push_px(8'hA5, 1'b1, 1'b0);
        @(negedge clk_in);
        check("t1_wr_addr_state", 32'({sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe}), 4'b0111);
        check("t1_addr", 32'(sram_addr), 0);
        check("t1_dq_out", 32'(sram_dq_out), 8'hA5);
        @(negedge clk_in);
        check("t1_we_low", 32'(sram_we_n), 0);
        @(negedge clk_in);
        check("t1_hold", 32'({sram_cs_n, sram_we_n, sram_dq_oe}), 3'b011);
        @(negedge clk_in);
        check("t1_idle", 32'({sram_cs_n, sram_dq_oe}), 2'b10);

        // Read latency and held data.
        do_reset();
        en = 1'b1;
        do_read(18'h00010, ack_lat, val_lat);
        check("t3_ack_lat", ack_lat, 1);
        check("t3_valid_lat", val_lat, 3);
        check("t3_rd_data", 32'(rd_data), 8'h3C);
        repeat (4) @(negedge clk_in);
        check("t3_rd_data_held", 32'(rd_data), 8'h3C);
        do_read(18'h00025, ack_lat, val_lat);
        check("t3_ack_lat2", ack_lat, 1);

        // Overflow with en=0, then drain.
        do_reset();
        push_px(8'h10, 1'b1, 1'b0);
        push_px(8'h11, 1'b0, 1'b0);
        push_px(8'h12, 1'b0, 1'b0);
        check("t2_ready_after3", 32'(wr_ready), 1);
        push_px(8'h13, 1'b0, 1'b0);
        check("t2_ready_after4", 32'(wr_ready), 0);
        check("t2_ovf_before", 32'(wr_overflow), 0);
        push_px(8'h14, 1'b0, 1'b0);
        check("t2_ovf_set", 32'(wr_overflow), 1);
        check("t2_cs_idle_en0", 32'(sram_cs_n), 1);
        @(negedge clk_in);
        en = 1'b1;
        repeat (30) @(negedge clk_in);
        check("t2_ready_drained", 32'(wr_ready), 1);
        check("t2_ovf_sticky", 32'(wr_overflow), 1);
        push_px(8'h15, 1'b0, 1'b1);
        check("t2_ovf_sticky2", 32'(wr_overflow), 1);
        push_px(8'h16, 1'b1, 1'b1);
        check("t2_ovf_clear", 32'(wr_overflow), 0);
        repeat (20) @(negedge clk_in);
        check("t2_log_size", wr_log.size(), 6);
        if (wr_log.size() == 6) begin
            check("t2_addr_after_drop", 32'(wr_log[4]), 4);
            check("t2_addr_sof", 32'(wr_log[5]), 0);
        end

        // Anti-starvation guard with rd_req held and the buffer full.
        do_reset();
        for (int i = 0; i < WBUF_DEPTH; i++) push_px(8'h40 + 8'(i), (i == 0), 1'b0);
        check("t4_full", 32'(wr_ready), 0);
        @(negedge clk_in);
        rd_addr = 18'h00020;
        rd_req  = 1'b1;
        en      = 1'b1;
        acks = 0;
        seen = 0;
        runs[0] = -1;
        runs[1] = -1;
        for (int i = 0; i < 400 && seen < 2; i++) begin
            @(negedge clk_in);
            if (wr_valid) begin
                wr_valid = 1'b0;
                wr_sof   = 1'b0;
            end
            if (rd_ack) acks++;
            if (!sram_we_n) begin
                runs[seen] = acks;
                acks = 0;
                seen++;
                if (seen == 1) drive_px(8'h77, 1'b0);
            end
        end
        rd_req = 1'b0;
        check("t4_reads_before_write1", runs[0], MAX_RD_WIN);
        check("t4_reads_before_write2", runs[1], MAX_RD_WIN);
        repeat (40) @(negedge clk_in);
        check("t4_wr_q_drained", wr_q.size(), 0);
        check("t4_rd_q_drained", rd_q.size(), 0);

        // Address wrap at FRAME_WORDS.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 17; i++) push_px(8'h80 + 8'(i), (i == 0), 1'b1);
        repeat (30) @(negedge clk_in);
        check("t5_log_size", wr_log.size(), 17);
        if (wr_log.size() == 17) begin
            check("t5_addr_first", 32'(wr_log[0]), 0);
            check("t5_addr_last_in_frame", 32'(wr_log[15]), FRAME_WORDS - 1);
            check("t5_addr_wrapped", 32'(wr_log[16]), 0);
        end
        check("t5_wr_q_drained", wr_q.size(), 0);

        // Reset during the write pulse.
        do_reset();
        push_px(8'hC1, 1'b1, 1'b0);
        push_px(8'hC2, 1'b0, 1'b0);
        push_px(8'hC3, 1'b0, 1'b0);
        @(negedge clk_in);
        en = 1'b1;
        n = 0;
        while (sram_we_n && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check("t6_saw_pulse", 32'(sram_we_n), 0);
        reset = 1'b1;
        wr_q.delete();
        m_next = '0;
        @(negedge clk_in);
        check("t6_we_n", 32'(sram_we_n), 1);
        check("t6_cs_n", 32'(sram_cs_n), 1);
        check("t6_dq_oe", 32'(sram_dq_oe), 0);
        check("t6_wr_ready", 32'(wr_ready), 1);
        reset = 1'b0;
        cs_seen = 0;
        repeat (15) begin
            @(negedge clk_in);
            if (!sram_cs_n) cs_seen++;
        end
        check("t6_fifo_empty_no_access", cs_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
